// File: rtl/alu_issue_ctrl.sv
// Issue controller between decode and the ALU: decodes an operation, drives the ALU,
// waits ALU_LATENCY cycles, captures the result and returns it on a valid/ready handshake.
module alu_issue_ctrl #(
  parameter int unsigned ALU_LATENCY = 0,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       alu_op,
  input  logic [2:0]       funct3,
  input  logic             funct7b5,
  input  logic             alu_src,
  input  logic [31:0]      rs1_val,
  input  logic [31:0]      rs2_val,
  input  logic [31:0]      imm,
  output logic [31:0]      alu_a,
  output logic [31:0]      alu_b,
  output logic [3:0]       alu_control,
  input  logic [31:0]      alu_result,
  input  logic             alu_zero,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic             out_zero,
  output logic             out_branch_taken,
  output logic             out_illegal,
  output logic [CNT_W-1:0] ops_issued
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_e;

  localparam logic [3:0] CTRL_ADD = 4'b0010;
  localparam logic [3:0] CTRL_SUB = 4'b0110;
  localparam logic [3:0] CTRL_AND = 4'b0000;
  localparam logic [3:0] CTRL_OR  = 4'b0001;
  localparam logic [3:0] LAT      = 4'(ALU_LATENCY);

  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [31:0]      aluA_q, aluA_d, aluB_q, aluB_d;
  logic [3:0]       ctrl_q, ctrl_d;
  logic             isBranch_q, isBranch_d, isBne_q, isBne_d;
  logic [31:0]      result_q, result_d;
  logic             zero_q, zero_d, taken_q, taken_d, illegal_q, illegal_d;
  logic [CNT_W-1:0] ops_q, ops_d;
  logic [3:0]       reqCtrl;
  logic             reqIllegal;

  always_comb begin
    reqCtrl    = CTRL_ADD;
    reqIllegal = 1'b0;
    case (alu_op)
      2'b00: reqCtrl = CTRL_ADD;
      2'b01: begin
        reqCtrl    = CTRL_SUB;
        reqIllegal = (funct3[2:1] != 2'b00);
      end
      2'b10: begin
        case (funct3)
          3'b000:  reqCtrl = (funct7b5 && !alu_src) ? CTRL_SUB : CTRL_ADD;
          3'b111:  reqCtrl = CTRL_AND;
          3'b110:  reqCtrl = CTRL_OR;
          default: reqIllegal = 1'b1;
        endcase
      end
      default: reqIllegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      aluA_q     <= '0;
      aluB_q     <= '0;
      ctrl_q     <= CTRL_ADD;
      isBranch_q <= 1'b0;
      isBne_q    <= 1'b0;
      result_q   <= '0;
      zero_q     <= 1'b0;
      taken_q    <= 1'b0;
      illegal_q  <= 1'b0;
      ops_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      aluA_q     <= aluA_d;
      aluB_q     <= aluB_d;
      ctrl_q     <= ctrl_d;
      isBranch_q <= isBranch_d;
      isBne_q    <= isBne_d;
      result_q   <= result_d;
      zero_q     <= zero_d;
      taken_q    <= taken_d;
      illegal_q  <= illegal_d;
      ops_q      <= ops_d;
    end
  end

  // Illegal requests skip EXEC entirely so the ALU is never issued and ops stays put.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    aluA_d     = aluA_q;
    aluB_d     = aluB_q;
    ctrl_d     = ctrl_q;
    isBranch_d = isBranch_q;
    isBne_d    = isBne_q;
    result_d   = result_q;
    zero_d     = zero_q;
    taken_d    = taken_q;
    illegal_d  = illegal_q;
    ops_d      = ops_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          aluA_d     = rs1_val;
          aluB_d     = alu_src ? imm : rs2_val;
          ctrl_d     = reqCtrl;
          cnt_d      = LAT;
          isBranch_d = (alu_op == 2'b01);
          isBne_d    = funct3[0];
          if (reqIllegal) begin
            state_d   = DONE;
            result_d  = '0;
            zero_d    = 1'b0;
            taken_d   = 1'b0;
            illegal_d = 1'b1;
          end else begin
            state_d = EXEC;
          end
        end
      end
      EXEC: begin
        if (cnt_q == 4'd0) begin
          result_d  = alu_result;
          zero_d    = alu_zero;
          taken_d   = isBranch_q && (isBne_q ? !alu_zero : alu_zero);
          illegal_d = 1'b0;
          ops_d     = ops_q + CNT_W'(1);
          state_d   = DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
  end

  assign alu_a            = aluA_q;
  assign alu_b            = aluB_q;
  assign alu_control      = ctrl_q;
  assign out_result       = result_q;
  assign out_zero         = zero_q;
  assign out_branch_taken = taken_q;
  assign out_illegal      = illegal_q;
  assign ops_issued       = ops_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench: two controllers (latency 0 / latency 3 with a 3-bit counter)
// compared every cycle against a transaction-level model, plus directed literal checks.
module tb_alu_issue_ctrl;

  logic clk = 1'b0;
  logic reset;
  logic [1:0] inValid, inReady, outValid, outZero, outTaken, outIllegal, aluZero;
  logic outReady;
  logic [1:0] aluOp;
  logic [2:0] funct3;
  logic funct7b5, aluSrc;
  logic [31:0] rs1Val, rs2Val, imm;
  logic [1:0][31:0] aluA, aluB, aluRes, outResult;
  logic [1:0][3:0] aluCtrl;
  logic [1:0][15:0] opsIssued;

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  int acceptCyc = 0;

  always #5 clk = ~clk;

  alu_issue_ctrl #(.ALU_LATENCY(0), .CNT_W(16)) dut0 (
    .clk(clk), .reset(reset), .in_valid(inValid[0]), .in_ready(inReady[0]),
    .alu_op(aluOp), .funct3(funct3), .funct7b5(funct7b5), .alu_src(aluSrc),
    .rs1_val(rs1Val), .rs2_val(rs2Val), .imm(imm),
    .alu_a(aluA[0]), .alu_b(aluB[0]), .alu_control(aluCtrl[0]),
    .alu_result(aluRes[0]), .alu_zero(aluZero[0]),
    .out_valid(outValid[0]), .out_ready(outReady), .out_result(outResult[0]),
    .out_zero(outZero[0]), .out_branch_taken(outTaken[0]), .out_illegal(outIllegal[0]),
    .ops_issued(opsIssued[0])
  );

  alu_issue_ctrl #(.ALU_LATENCY(3), .CNT_W(3)) dut1 (
    .clk(clk), .reset(reset), .in_valid(inValid[1]), .in_ready(inReady[1]),
    .alu_op(aluOp), .funct3(funct3), .funct7b5(funct7b5), .alu_src(aluSrc),
    .rs1_val(rs1Val), .rs2_val(rs2Val), .imm(imm),
    .alu_a(aluA[1]), .alu_b(aluB[1]), .alu_control(aluCtrl[1]),
    .alu_result(aluRes[1]), .alu_zero(aluZero[1]),
    .out_valid(outValid[1]), .out_ready(outReady), .out_result(outResult[1]),
    .out_zero(outZero[1]), .out_branch_taken(outTaken[1]), .out_illegal(outIllegal[1]),
    .ops_issued(opsIssued[1][2:0])
  );
  assign opsIssued[1][15:3] = '0;

  // Stand-in for the existing ALU unit, using its documented control encoding.
  always_comb begin
    aluRes  = '0;
    aluZero = '0;
    for (int i = 0; i < 2; i++) begin
      case (aluCtrl[i])
        4'b0010: aluRes[i] = aluA[i] + aluB[i];
        4'b0110: aluRes[i] = aluA[i] - aluB[i];
        4'b0000: aluRes[i] = aluA[i] & aluB[i];
        4'b0001: aluRes[i] = aluA[i] | aluB[i];
        default: aluRes[i] = 32'hDEAD_BEEF;
      endcase
      aluZero[i] = (aluRes[i] == 32'd0);
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Operation kinds: 0 add, 1 sub, 2 and, 3 or; branch: 0 none, 1 beq, 2 bne.
  function automatic void decodeReq(input logic [1:0] op, input logic [2:0] f3, input logic f7,
                                    input logic src, output int kind, output int br, output bit ill);
    kind = 0; br = 0; ill = 1'b0;
    if (op == 2'd0) kind = 0;
    else if (op == 2'd1) begin
      kind = 1;
      if (f3 == 3'd0) br = 1;
      else if (f3 == 3'd1) br = 2;
      else ill = 1'b1;
    end else if (op == 2'd2) begin
      if (f3 == 3'd0) kind = (f7 && !src) ? 1 : 0;
      else if (f3 == 3'd7) kind = 2;
      else if (f3 == 3'd6) kind = 3;
      else ill = 1'b1;
    end else ill = 1'b1;
  endfunction

  function automatic logic [3:0] kindCode(input int kind);
    case (kind)
      1: return 4'b0110;
      2: return 4'b0000;
      3: return 4'b0001;
      default: return 4'b0010;
    endcase
  endfunction

  function automatic logic [31:0] kindCalc(input int kind, input logic [31:0] a, input logic [31:0] b);
    case (kind)
      1: return a - b;
      2: return a & b;
      3: return a | b;
      default: return a + b;
    endcase
  endfunction

  int lat[2] = '{0, 3};
  logic [15:0] opsMask[2] = '{16'hFFFF, 16'h0007};
  bit mBusy[2], mValid[2], mPend[2], mCtrlKnown[2], mZero[2], mTaken[2], mIll[2];
  int mCap[2], mKind[2], mBr[2], mOps[2];
  logic [31:0] mA[2], mB[2], mRes[2];
  logic [3:0] mCtrl[2];

  // Transaction-level model: a request is accepted when idle, answered 1+latency edges later.
  always @(posedge clk) begin
    int kind, br;
    bit ill;
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        mBusy[i] = 0; mValid[i] = 0; mPend[i] = 0; mCtrlKnown[i] = 1;
        mA[i] = '0; mB[i] = '0; mCtrl[i] = 4'b0010; mRes[i] = '0;
        mZero[i] = 0; mTaken[i] = 0; mIll[i] = 0; mOps[i] = 0;
      end else if (mValid[i]) begin
        if (outReady) begin mValid[i] = 0; mBusy[i] = 0; end
      end else if (!mBusy[i] && inValid[i]) begin
        decodeReq(aluOp, funct3, funct7b5, aluSrc, kind, br, ill);
        mA[i] = rs1Val;
        mB[i] = aluSrc ? imm : rs2Val;
        mBusy[i] = 1;
        if (ill) begin
          mValid[i] = 1; mIll[i] = 1; mRes[i] = '0; mZero[i] = 0; mTaken[i] = 0;
          mCtrlKnown[i] = 0;
        end else begin
          mCtrl[i] = kindCode(kind); mCtrlKnown[i] = 1;
          mPend[i] = 1; mCap[i] = cyc + 1 + lat[i]; mKind[i] = kind; mBr[i] = br;
        end
      end else if (mPend[i] && cyc == mCap[i]) begin
        mRes[i] = kindCalc(mKind[i], mA[i], mB[i]);
        mZero[i] = (mRes[i] == 32'd0);
        mTaken[i] = (mBr[i] == 1) ? mZero[i] : ((mBr[i] == 2) ? !mZero[i] : 1'b0);
        mIll[i] = 0; mOps[i]++; mPend[i] = 0; mValid[i] = 1;
      end
    end
  end

  // Every-cycle comparison against the model, shortly after each rising edge.
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < 2; i++) begin
      checkOutput($sformatf("in_ready%0d", i), 32'(inReady[i]), 32'(!mBusy[i]));
      checkOutput($sformatf("out_valid%0d", i), 32'(outValid[i]), 32'(mValid[i]));
      checkOutput($sformatf("ops%0d", i), 32'(opsIssued[i]), 32'(16'(mOps[i]) & opsMask[i]));
      checkOutput($sformatf("alu_a%0d", i), aluA[i], mA[i]);
      checkOutput($sformatf("alu_b%0d", i), aluB[i], mB[i]);
      if (mCtrlKnown[i]) checkOutput($sformatf("alu_ctrl%0d", i), 32'(aluCtrl[i]), 32'(mCtrl[i]));
      if (mValid[i]) begin
        checkOutput($sformatf("out_result%0d", i), outResult[i], mRes[i]);
        checkOutput($sformatf("out_zero%0d", i), 32'(outZero[i]), 32'(mZero[i]));
        checkOutput($sformatf("out_taken%0d", i), 32'(outTaken[i]), 32'(mTaken[i]));
        checkOutput($sformatf("out_illegal%0d", i), 32'(outIllegal[i]), 32'(mIll[i]));
      end
    end
  end

  task automatic applyStimulus(input int i, input logic [1:0] op, input logic [2:0] f3,
                               input logic f7, input logic src, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] im);
    int n = 0;
    @(negedge clk);
    aluOp = op; funct3 = f3; funct7b5 = f7; aluSrc = src;
    rs1Val = a; rs2Val = b; imm = im;
    inValid[i] = 1'b1;
    while (!inReady[i] && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) begin
      checks++;
      $display("[TB] FAIL accept_timeout dut%0d: in_ready stayed 0, required 1", i);
    end
    @(posedge clk);
    @(negedge clk);
    inValid[i] = 1'b0;
    acceptCyc = cyc;
  endtask

  task automatic waitResp(input int i, output int delta);
    int n = 0;
    while (!outValid[i] && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) begin
      checks++;
      $display("[TB] FAIL resp_timeout dut%0d: out_valid stayed 0, required 1", i);
    end
    delta = cyc - acceptCyc;
  endtask

  logic [1:0]  wOp [9] = '{2'd2, 2'd0, 2'd2, 2'd1, 2'd2, 2'd2, 2'd1, 2'd2, 2'd0};
  logic [2:0]  wF3 [9] = '{3'd6, 3'd0, 3'd7, 3'd1, 3'd0, 3'd0, 3'd0, 3'd6, 3'd0};
  logic        wF7 [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
  logic        wSrc[9] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

  initial begin
    int d;
    reset = 1'b1; inValid = '0; outReady = 1'b1;
    aluOp = '0; funct3 = '0; funct7b5 = 1'b0; aluSrc = 1'b0;
    rs1Val = '0; rs2Val = '0; imm = '0;
    repeat (2) @(negedge clk);
    checkOutput("reset_in_ready", 32'(inReady[0]), 32'd1);
    checkOutput("reset_ctrl", 32'(aluCtrl[0]), 32'h2);
    reset = 1'b0;

    applyStimulus(0, 2'd2, 3'd0, 1'b0, 1'b0, 32'd5, 32'd7, 32'd0);
    checkOutput("add_ctrl", 32'(aluCtrl[0]), 32'h2);
    waitResp(0, d);
    checkOutput("add_latency", 32'(d), 32'd1);
    checkOutput("add_result", outResult[0], 32'd12);
    checkOutput("add_zero", 32'(outZero[0]), 32'd0);
    checkOutput("add_ops", 32'(opsIssued[0]), 32'd1);

    applyStimulus(0, 2'd1, 3'd0, 1'b0, 1'b0, 32'h1234, 32'h1234, 32'd0);
    checkOutput("beq_ctrl", 32'(aluCtrl[0]), 32'h6);
    waitResp(0, d);
    checkOutput("beq_zero", 32'(outZero[0]), 32'd1);
    checkOutput("beq_taken", 32'(outTaken[0]), 32'd1);

    applyStimulus(0, 2'd1, 3'd1, 1'b0, 1'b0, 32'h1234, 32'h1234, 32'd0);
    waitResp(0, d);
    checkOutput("bne_zero", 32'(outZero[0]), 32'd1);
    checkOutput("bne_taken", 32'(outTaken[0]), 32'd0);

    applyStimulus(0, 2'd2, 3'd0, 1'b1, 1'b1, 32'd10, 32'd99, 32'd3);
    checkOutput("imm_ctrl", 32'(aluCtrl[0]), 32'h2);
    waitResp(0, d);
    checkOutput("imm_result", outResult[0], 32'd13);

    applyStimulus(0, 2'd2, 3'd0, 1'b1, 1'b0, 32'd10, 32'd3, 32'd0);
    checkOutput("sub_ctrl", 32'(aluCtrl[0]), 32'h6);
    waitResp(0, d);
    checkOutput("sub_result", outResult[0], 32'd7);
    checkOutput("sub_ops", 32'(opsIssued[0]), 32'd5);

    applyStimulus(0, 2'd3, 3'd0, 1'b0, 1'b0, 32'd1, 32'd2, 32'd3);
    waitResp(0, d);
    checkOutput("ill11_latency", 32'(d), 32'd0);
    checkOutput("ill11_flag", 32'(outIllegal[0]), 32'd1);
    checkOutput("ill11_result", outResult[0], 32'd0);
    checkOutput("ill11_ops", 32'(opsIssued[0]), 32'd5);

    applyStimulus(0, 2'd2, 3'd4, 1'b0, 1'b0, 32'd1, 32'd2, 32'd3);
    waitResp(0, d);
    checkOutput("ill100_latency", 32'(d), 32'd0);
    checkOutput("ill100_flag", 32'(outIllegal[0]), 32'd1);
    checkOutput("ill100_ops", 32'(opsIssued[0]), 32'd5);

    // Backpressure on the latency-3 controller.
    @(negedge clk);
    outReady = 1'b0;
    applyStimulus(1, 2'd2, 3'd7, 1'b0, 1'b0, 32'hF0F0, 32'h0FF0, 32'd0);
    checkOutput("and_ctrl", 32'(aluCtrl[1]), 32'h0);
    waitResp(1, d);
    checkOutput("and_latency", 32'(d), 32'd4);
    repeat (5) begin
      @(negedge clk);
      checkOutput("bp_result", outResult[1], 32'h00F0);
      checkOutput("bp_valid", 32'(outValid[1]), 32'd1);
      checkOutput("bp_in_ready", 32'(inReady[1]), 32'd0);
    end
    outReady = 1'b1;
    @(negedge clk);
    checkOutput("bp_release_valid", 32'(outValid[1]), 32'd0);
    checkOutput("bp_release_in_ready", 32'(inReady[1]), 32'd1);

    // Reset while the latency-3 controller is executing.
    applyStimulus(1, 2'd2, 3'd0, 1'b0, 1'b0, 32'd1, 32'd2, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("rst_in_ready", 32'(inReady[1]), 32'd1);
    checkOutput("rst_valid", 32'(outValid[1]), 32'd0);
    checkOutput("rst_ops", 32'(opsIssued[1]), 32'd0);
    repeat (8) begin
      @(negedge clk);
      checkOutput("rst_no_valid", 32'(outValid[1]), 32'd0);
    end

    // Nine legal operations wrap the 3-bit counter back to 1.
    for (int k = 0; k < 9; k++) begin
      applyStimulus(1, wOp[k], wF3[k], wF7[k], wSrc[k], 32'h00F0 + 32'(k), 32'h000F, 32'd4);
      waitResp(1, d);
      if (k == 0) checkOutput("or_result", outResult[1], 32'h00FF);
      if (k == 7) checkOutput("wrap_ops0", 32'(opsIssued[1]), 32'd0);
      if (k == 8) checkOutput("wrap_ops1", 32'(opsIssued[1]), 32'd1);
    end

    @(negedge clk);
    @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
